// File: rtl/ex_mem_stage_reg_if.sv
// rtl/ex_mem_stage_reg_if.sv - EX/MEM stage handshake and payload bundle.
interface ex_mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              RegWrite;
  logic              MemtoReg;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] ALUresult;
  logic [DATA_W-1:0] writedata;
  logic [REG_W-1:0]  writeReg;
  logic              out_valid;
  logic              out_ready;
  logic              RegWriteOut;
  logic              MemtoRegOut;
  logic              MemWriteOut;
  logic              MemReadOut;
  logic [DATA_W-1:0] ALUresultOut;
  logic [DATA_W-1:0] writedataOut;
  logic [REG_W-1:0]  writeRegOut;

  modport master (
    output flush, in_valid, RegWrite, MemtoReg, MemWrite, MemRead,
           ALUresult, writedata, writeReg, out_ready,
    input  in_ready, out_valid, RegWriteOut, MemtoRegOut, MemWriteOut,
           MemReadOut, ALUresultOut, writedataOut, writeRegOut
  );

  modport slave (
    input  flush, in_valid, RegWrite, MemtoReg, MemWrite, MemRead,
           ALUresult, writedata, writeReg, out_ready,
    output in_ready, out_valid, RegWriteOut, MemtoRegOut, MemWriteOut,
           MemReadOut, ALUresultOut, writedataOut, writeRegOut
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX/MEM pipeline register with two-entry skid buffer and flush.
// Define EXMEM_FWD_EN to add the fwd_valid/fwd_reg/fwd_data forwarding outputs.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  ex_mem_stage_reg_if.slave bus
`ifdef EXMEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // Entry layout: {RegWrite, MemtoReg, MemWrite, MemRead, ALUresult, writedata, writeReg}
  localparam int ENT_W = 4 + 2 * DATA_W + REG_W;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;
  logic             drain;
  logic [3:0]       ctrl_raw;

  assign in_ent = {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.MemRead,
                   bus.ALUresult, bus.writedata, bus.writeReg};

  // in_ready depends only on registered state and rst, never on out_ready
  assign bus.in_ready = !skid_valid_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = main_valid_q && bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = in_ent;
        end
      end
    end else if (accept) begin
      skid_d       = in_ent;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Bubbles must never look like memory or register-file writes
  assign ctrl_raw         = main_q[ENT_W-1 -: 4];
  assign bus.out_valid    = main_valid_q;
  assign bus.RegWriteOut  = ctrl_raw[3] && main_valid_q;
  assign bus.MemtoRegOut  = ctrl_raw[2] && main_valid_q;
  assign bus.MemWriteOut  = ctrl_raw[1] && main_valid_q;
  assign bus.MemReadOut   = ctrl_raw[0] && main_valid_q;
  assign bus.ALUresultOut = main_q[REG_W + DATA_W +: DATA_W];
  assign bus.writedataOut = main_q[REG_W +: DATA_W];
  assign bus.writeRegOut  = main_q[REG_W-1:0];

`ifdef EXMEM_FWD_EN
  assign fwd_valid = main_valid_q && ctrl_raw[3] && !ctrl_raw[0]
                     && (main_q[REG_W-1:0] != '0);
  assign fwd_reg   = main_q[REG_W-1:0];
  assign fwd_data  = main_q[REG_W + DATA_W +: DATA_W];
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - self-checking bench for ex_mem_stage_reg.
// Queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_ex_mem_stage_reg;
  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [3:0]    ctrl;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [RW-1:0] wr;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  ex_mem_stage_reg_if #(.DATA_W(DW), .REG_W(RW)) bus ();

`ifdef EXMEM_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_reg;
  logic [DW-1:0] fwd_data;
`endif

  ex_mem_stage_reg #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef EXMEM_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held instructions in arrival order, plus the last payload shown on the outputs
  ent_t q[$];
  ent_t shown;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      shown = '0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      int n;
      n = q.size();
      if (n > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && n < 2)
        q.push_back({bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.MemRead,
                     bus.ALUresult, bus.writedata, bus.writeReg});
      if (q.size() > 0) shown = q[0];
    end
  end

  always @(negedge clk) begin
    logic       v;
    logic [3:0] c;
    v = (q.size() > 0);
    c = v ? shown.ctrl : 4'b0;
    chk("in_ready", bus.in_ready, !rst && q.size() < 2);
    chk("out_valid", bus.out_valid, v);
    chk("ctrl_out", {bus.RegWriteOut, bus.MemtoRegOut, bus.MemWriteOut, bus.MemReadOut}, c);
    chk("alu_out", bus.ALUresultOut, shown.alu);
    chk("wd_out", bus.writedataOut, shown.wd);
    chk("wr_out", bus.writeRegOut, shown.wr);
`ifdef EXMEM_FWD_EN
    chk("fwd_valid", fwd_valid, v && c[3] && !c[0] && shown.wr != 0);
    chk("fwd_reg", fwd_reg, shown.wr);
    chk("fwd_data", fwd_data, shown.alu);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [3:0] ctrl, input logic [DW-1:0] alu,
                      input logic [RW-1:0] wr);
    bus.in_valid = v;
    {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.MemRead} = ctrl;
    bus.ALUresult = alu;
    bus.writedata = ~alu;
    bus.writeReg  = wr;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b1, 4'b1111, 32'hDEAD_BEEF, 5'd9);
    step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_alu", bus.ALUresultOut, 32'h0);
    rst = 1'b0;
    send(1'b0, 4'b0, 32'h0, 5'd0);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Streaming
    send(1'b1, 4'b1000, 32'h11, 5'd3);
    step();
    chk("s1_alu", bus.ALUresultOut, 32'h11);
    chk("s1_wr", bus.writeRegOut, 5'd3);
    send(1'b1, 4'b1000, 32'h22, 5'd4);
    step();
    chk("s2_alu", bus.ALUresultOut, 32'h22);
    chk("s2_valid", bus.out_valid, 1'b1);
    send(1'b1, 4'b1000, 32'h33, 5'd5);
    step();
    chk("s3_alu", bus.ALUresultOut, 32'h33);
    chk("s3_regwrite", bus.RegWriteOut, 1'b1);
    chk("s3_in_ready", bus.in_ready, 1'b1);
    send(1'b0, 4'b0, 32'h0, 5'd0);
    step();
    chk("s_drained", bus.out_valid, 1'b0);

    // Stall and skid
    bus.out_ready = 1'b0;
    send(1'b1, 4'b1000, 32'hA, 5'd1);
    step();
    send(1'b1, 4'b1000, 32'hB, 5'd2);
    step();
    chk("stall_alu", bus.ALUresultOut, 32'hA);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    send(1'b0, 4'b0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    chk("skid_alu", bus.ALUresultOut, 32'hB);
    chk("skid_in_ready", bus.in_ready, 1'b1);
    step();
    chk("skid_drained", bus.out_valid, 1'b0);

    // Flush with both entries full
    bus.out_ready = 1'b0;
    send(1'b1, 4'b1010, 32'hC1, 5'd6);
    step();
    send(1'b1, 4'b1010, 32'hC2, 5'd6);
    step();
    bus.flush = 1'b1;
    send(1'b1, 4'b1010, 32'hC3, 5'd6);
    step();
    bus.flush = 1'b0;
    send(1'b0, 4'b0, 32'h0, 5'd0);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_memwrite", bus.MemWriteOut, 1'b0);
    chk("flush_regwrite", bus.RegWriteOut, 1'b0);
    step();
    chk("flush_absent", bus.out_valid, 1'b0);

    // Bubble gating
    bus.out_ready = 1'b1;
    send(1'b1, 4'b0010, 32'hD, 5'd0);
    step();
    chk("bub_memwrite", bus.MemWriteOut, 1'b1);
    send(1'b0, 4'b0, 32'h0, 5'd0);
    step();
    chk("bub_gated", bus.MemWriteOut, 1'b0);
    chk("bub_alu_kept", bus.ALUresultOut, 32'hD);

`ifdef EXMEM_FWD_EN
    send(1'b1, 4'b1000, 32'h55, 5'd7);
    step();
    chk("fwd_v", fwd_valid, 1'b1);
    chk("fwd_r", fwd_reg, 5'd7);
    chk("fwd_d", fwd_data, 32'h55);
    send(1'b1, 4'b1001, 32'h55, 5'd7);
    step();
    chk("fwd_memread", fwd_valid, 1'b0);
    send(1'b1, 4'b1000, 32'h55, 5'd0);
    step();
    chk("fwd_r0", fwd_valid, 1'b0);
    send(1'b0, 4'b0, 32'h0, 5'd0);
    step();
`endif

    // Randomized traffic, occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.flush     = ($urandom_range(0, 29) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      send($urandom_range(0, 3) != 0, 4'($urandom), $urandom, 5'($urandom));
      step();
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    send(1'b0, 4'b0, 32'h0, 5'd0);
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
